// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus decoder hand-off.
// master = fetch unit, slave = memory/decoder side.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: issues word-aligned fetches, holds one
// instruction for the decoder, and discards in-flight data across redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_count,
    instr_fetch_if.master bus
);

    localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {REQ, WAIT, HOLD, FLUSH} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] instr_word;
    logic [31:0] instr_addr;
    logic        handoff;
    logic        unused_pc_bits;

    always_comb begin
        target         = {redirect_pc[31:2], 2'b00};
        unused_pc_bits = ^redirect_pc[1:0];
        // rst_n gating keeps the request low while reset holds the FSM in REQ
        bus.imem_req_valid = rst_n && (state == REQ);
        bus.imem_addr      = pc;
        bus.instr_valid    = (state == HOLD) && !stall && !redirect_valid;
        bus.instr_out      = instr_word;
        bus.instr_pc       = instr_addr;
        handoff            = bus.instr_valid && bus.instr_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQ;
            pc          <= START_PC;
            instr_word  <= '0;
            instr_addr  <= '0;
            fetch_count <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (redirect_valid) begin
                        pc <= target;
                        // request for the old pc was still accepted; its data must be thrown away
                        if (bus.imem_req_ready) state <= FLUSH;
                    end else if (bus.imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= bus.imem_resp_valid ? REQ : FLUSH;
                    end else if (bus.imem_resp_valid) begin
                        instr_word <= bus.imem_resp_data;
                        instr_addr <= pc;
                        pc         <= pc + 32'd4;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (handoff) begin
                        fetch_count <= fetch_count + 32'd1;
                        state       <= REQ;
                    end
                end
                FLUSH: begin
                    if (redirect_valid) pc <= target;
                    if (bus.imem_resp_valid) state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the fetch unit.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    instr_fetch_if bus();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_count    (fetch_count),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0040A283;
        return (addr * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // Memory responder: one response per accepted request, 1 + delay cycles later
    bit          acc_seen;
    logic [31:0] acc_addr;
    bit          pend;
    int          delay;
    logic [31:0] paddr;
    int          mem_lat;
    bit          rand_lat;

    always @(negedge clk) begin
        acc_seen = rst_n && bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_addr;
    end

    task automatic mem_step();
        if (acc_seen) begin
            pend  = 1'b1;
            delay = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
            paddr = acc_addr;
        end
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom;
        if (pend) begin
            if (delay == 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(paddr);
                pend = 1'b0;
            end else begin
                delay--;
            end
        end
    endtask

    task automatic cyc(input logic s, input logic rv, input logic [31:0] rp,
                       input logic rdy, input logic irdy);
        @(posedge clk);
        #1;
        mem_step();
        stall              = s;
        redirect_valid     = rv;
        redirect_pc        = rp;
        bus.imem_req_ready = rdy;
        bus.instr_ready    = irdy;
    endtask

    // Transaction-level model: in-flight request flag, drop flag, held instruction.
    logic [31:0] m_pc, m_out, m_ipc, m_cnt;
    bit          m_busy, m_drop, m_held;
    bit          e_req, e_iv, m_acc;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_out = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
            m_busy = 1'b0; m_drop = 1'b0; m_held = 1'b0;
        end
        e_req = rst_n && !m_busy && !m_held;
        e_iv  = rst_n && m_held && !stall && !redirect_valid;
        chk("model_req_valid",   32'(bus.imem_req_valid), 32'(e_req));
        chk("model_imem_addr",   bus.imem_addr,           m_pc);
        chk("model_instr_valid", 32'(bus.instr_valid),    32'(e_iv));
        chk("model_instr_out",   bus.instr_out,           m_out);
        chk("model_instr_pc",    bus.instr_pc,            m_ipc);
        chk("model_fetch_count", fetch_count,             m_cnt);
        if (rst_n) begin
            m_acc = e_req && bus.imem_req_ready;
            if (redirect_valid) begin
                m_pc   = {redirect_pc[31:2], 2'b00};
                m_held = 1'b0;
                if (m_acc) begin
                    m_busy = 1'b1;
                    m_drop = 1'b1;
                end else if (m_busy && bus.imem_resp_valid) begin
                    m_busy = 1'b0;
                end else if (m_busy) begin
                    m_drop = 1'b1;
                end
            end else if (m_acc) begin
                m_busy = 1'b1;
                m_drop = 1'b0;
            end else if (m_busy && bus.imem_resp_valid) begin
                m_busy = 1'b0;
                if (!m_drop) begin
                    m_held = 1'b1;
                    m_out  = bus.imem_resp_data;
                    m_ipc  = m_pc;
                    m_pc   = m_pc + 32'd4;
                end
            end else if (e_iv && bus.instr_ready) begin
                m_held = 1'b0;
                m_cnt  = m_cnt + 32'd1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rp;
        logic        rv;
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        bus.imem_req_ready = 1'b0; bus.instr_ready = 1'b0;
        bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
        pend = 1'b0; delay = 0; paddr = '0; mem_lat = 0; rand_lat = 1'b0;

        repeat (3) cyc(0, 0, 32'h0, 0, 0);
        #1;
        chk("rst_req_valid",   32'(bus.imem_req_valid), 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid),    32'h0);
        chk("rst_instr_out",   bus.instr_out,           32'h0);
        chk("rst_instr_pc",    bus.instr_pc,            32'h0);
        chk("rst_fetch_count", fetch_count,             32'h0);

        // first fetch after reset, single-cycle memory
        cyc(0, 0, 32'h0, 1, 1); rst_n = 1'b1; #1;
        chk("c0_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("c0_addr",      bus.imem_addr,           32'h0);
        cyc(0, 0, 32'h0, 1, 1); #1;
        chk("c1_req_valid", 32'(bus.imem_req_valid), 32'h0);
        cyc(0, 0, 32'h0, 1, 1); #1;
        chk("c2_instr_valid", 32'(bus.instr_valid), 32'h1);
        chk("c2_instr_out",   bus.instr_out,        32'h0040A283);
        chk("c2_instr_pc",    bus.instr_pc,         32'h0);
        cyc(0, 0, 32'h0, 1, 1); #1;
        chk("c3_fetch_count", fetch_count,   32'h1);
        chk("c3_addr",        bus.imem_addr, 32'h4);

        // stall during HOLD
        cyc(0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 32'h0, 0, 1); #1;
            chk("stall_instr_valid", 32'(bus.instr_valid), 32'h0);
            chk("stall_instr_out",   bus.instr_out,        mem_word(32'h4));
        end
        cyc(0, 0, 32'h0, 0, 1); #1;
        chk("unstall_instr_valid", 32'(bus.instr_valid), 32'h1);
        chk("unstall_count_pre",   fetch_count,          32'h1);
        cyc(0, 0, 32'h0, 1, 1); #1;
        chk("unstall_count_post", fetch_count,   32'h2);
        chk("unstall_addr",       bus.imem_addr, 32'h8);

        // redirect while waiting, response two cycles later is dropped
        mem_lat = 2;
        cyc(0, 1, 32'h0000_0100, 0, 1); #1;
        chk("wredir_req_valid", 32'(bus.imem_req_valid), 32'h0);
        cyc(0, 0, 32'h0, 0, 1); #1;
        chk("flush_addr",        bus.imem_addr,           32'h100);
        chk("flush_req_valid",   32'(bus.imem_req_valid), 32'h0);
        cyc(0, 0, 32'h0, 0, 1); #1;
        chk("drop_instr_valid",  32'(bus.instr_valid),    32'h0);
        chk("drop_req_valid",    32'(bus.imem_req_valid), 32'h0);
        mem_lat = 0;
        cyc(0, 0, 32'h0, 1, 1); #1;
        chk("postflush_req_valid", 32'(bus.imem_req_valid), 32'h1);
        chk("postflush_addr",      bus.imem_addr,           32'h100);
        chk("postflush_iv",        32'(bus.instr_valid),    32'h0);
        cyc(0, 0, 32'h0, 0, 1);

        // redirect in HOLD suppresses hand-off
        cyc(0, 1, 32'h0000_0203, 0, 1); #1;
        chk("hredir_instr_valid", 32'(bus.instr_valid), 32'h0);
        chk("hredir_instr_pc",    bus.instr_pc,         32'h100);
        cyc(0, 1, 32'hFFFF_FFFC, 0, 1); #1;
        chk("hredir_count", fetch_count,             32'h2);
        chk("hredir_addr",  bus.imem_addr,           32'h200);
        chk("hredir_req",   32'(bus.imem_req_valid), 32'h1);

        // address wrap
        cyc(0, 0, 32'h0, 1, 1); #1;
        chk("wrap_addr_hi", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 0, 32'h0, 0, 1); #1;
        chk("wrap_instr_valid", 32'(bus.instr_valid), 32'h1);
        chk("wrap_instr_pc",    bus.instr_pc,         32'hFFFF_FFFC);
        mem_lat = 2;
        cyc(0, 0, 32'h0, 1, 1); #1;
        chk("wrap_addr_lo", bus.imem_addr, 32'h0);
        chk("wrap_count",   fetch_count,   32'h3);

        // reset mid-WAIT, stale response arrives after release
        cyc(0, 0, 32'h0, 0, 0); rst_n = 1'b0; #1;
        chk("midrst_req_valid",   32'(bus.imem_req_valid), 32'h0);
        chk("midrst_addr",        bus.imem_addr,           32'h0);
        chk("midrst_instr_valid", 32'(bus.instr_valid),    32'h0);
        chk("midrst_instr_out",   bus.instr_out,           32'h0);
        chk("midrst_instr_pc",    bus.instr_pc,            32'h0);
        chk("midrst_count",       fetch_count,             32'h0);
        cyc(0, 0, 32'h0, 0, 0); rst_n = 1'b1;
        cyc(0, 0, 32'h0, 0, 0); #1;
        chk("stale_instr_valid", 32'(bus.instr_valid),    32'h0);
        chk("stale_req_valid",   32'(bus.imem_req_valid), 32'h1);
        cyc(0, 0, 32'h0, 0, 0); #1;
        chk("stale_after_req", 32'(bus.imem_req_valid), 32'h1);
        chk("stale_after_addr", bus.imem_addr,          32'h0);
        chk("stale_after_iv",  32'(bus.instr_valid),    32'h0);
        chk("stale_after_out", bus.instr_out,           32'h0);

        // randomized traffic
        mem_lat  = 0;
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0:       rp = $urandom;
                1:       rp = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: rp = 32'($urandom_range(0, 255));
            endcase
            cyc($urandom_range(0, 3) == 0, rv, rp,
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                pend  = 1'b0;
            end else begin
                rst_n = 1'b1;
            end
        end
        cyc(0, 0, 32'h0, 0, 0);
        cyc(0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  back-end hold; blocks hand-off to the decoder.
REQ-005 redirect_valid  input  1  branch/jump redirect strobe, single cycle.
REQ-006 redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0).
REQ-007 imem_req_valid  output  1  fetch request to instruction memory.
REQ-008 imem_req_ready  input  1  memory accepts request this cycle.
REQ-009 imem_addr  output  32  fetch address, word aligned.
REQ-010 imem_resp_valid  input  1  read data valid; one response per accepted request, at least 1 cycle after acceptance.
REQ-011 imem_resp_data  input  32  fetched instruction word.
REQ-012 instr_valid  output  1  instr_out/instr_pc valid for the decoder.
REQ-013 instr_ready  input  1  decoder accepts instruction.
REQ-014 instr_out  output  32  instruction word, drives decoder instruction input.
REQ-015 instr_pc  output  32  address of instr_out.
REQ-016 fetch_count  output  32  number of instructions handed to the decoder.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, FLUSH; at most one memory request outstanding.
REQ-018 REQ: imem_req_valid=1, imem_addr=pc; req accepted (imem_req_ready=1) -> WAIT; redirect -> pc<=redirect_pc, stay REQ, no request counted as accepted unless imem_req_ready was high that cycle (then -> FLUSH).
REQ-019 WAIT: imem_resp_valid without redirect -> instr_out<=imem_resp_data, instr_pc<=pc, pc<=pc+4, -> HOLD.
REQ-020 WAIT: redirect without imem_resp_valid -> pc<=redirect_pc, -> FLUSH; redirect with imem_resp_valid same cycle -> data dropped, pc<=redirect_pc, -> REQ.
REQ-021 FLUSH: imem_resp_valid -> data dropped, -> REQ; redirect in FLUSH -> pc<=redirect_pc, stay FLUSH (or -> REQ if imem_resp_valid same cycle).
REQ-022 instr_valid SHALL equal (state==HOLD) && !stall && !redirect_valid, combinationally.
REQ-023 HOLD: instr_valid && instr_ready -> fetch_count<=fetch_count+1, -> REQ; redirect -> pc<=redirect_pc, -> REQ, no hand-off, count unchanged.
REQ-024 instr_out and instr_pc SHALL remain stable while in HOLD.
REQ-025 pc and imem_addr SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0); fetch_count wraps modulo 2^32.
REQ-026 imem_req_valid SHALL be 0 in WAIT, HOLD, FLUSH; imem_addr SHALL hold pc in every state.
REQ-027 Latency with single-cycle memory (ready=1, response next cycle): request cycle N, response N+1, instr_valid N+2, next request N+3.
REQ-028 stall SHALL NOT affect REQ, WAIT, or FLUSH progress; only the HOLD hand-off.

Reset
REQ-029 rst_n low SHALL asynchronously force state=REQ, pc=RESET_PC, instr_out=0, instr_pc=0, fetch_count=0.
REQ-030 imem_req_valid and instr_valid SHALL be 0 while rst_n is low.
REQ-031 First request SHALL be issued in the first cycle after rst_n deasserts, imem_addr=RESET_PC.
REQ-032 Reset asserted during WAIT or FLUSH SHALL abandon the pending response; a response arriving after reset release in REQ SHALL be ignored.

Verification
REQ-033 Reset release, RESET_PC=0, memory returns 32'h0040A283 one cycle after accept, instr_ready=1 -> instr_valid at cycle 2, instr_out=32'h0040A283, instr_pc=0, fetch_count=1, next imem_addr=4.
REQ-034 Instruction held in HOLD, stall=1 for 5 cycles -> instr_valid=0, instr_out stable; stall=0 -> hand-off in that cycle, fetch_count increments once.
REQ-035 Redirect to 32'h0000_0100 while in WAIT, response arrives 2 cycles later -> response dropped, next imem_addr=32'h0000_0100, no instr_valid for the dropped word.
REQ-036 Redirect to 32'h0000_0203 in HOLD with instr_ready=1 -> no hand-off, fetch_count unchanged, next imem_addr=32'h0000_0200.
REQ-037 pc=32'hFFFF_FFFC fetched and handed off -> next imem_addr=32'h0000_0000.
REQ-038 rst_n pulsed low mid-WAIT -> all outputs zero immediately, first post-reset request at RESET_PC, stale response ignored.
